memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: MemoryStage

Interface
REQ-001 SHALL have parameter: WAIT_CYCLES, default 2, SRAM clock cycles per 16-bit half access (legal range 1..15).
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- destination_in  in  4  destination register number from EX/MEM
- aluResult_in  in  32  effective address, or ALU result
- storeValue_in  in  32  word to store
- memoryReadEnabled_in  in  1  load instruction
- memoryWriteEnabled_in  in  1  store instruction
- writeBackEnabled_in  in  1  instruction writes a register
- destination  out  4  to MEM/WB register
- data  out  32  assembled load word
- aluResult  out  32  to MEM/WB register
- memoryReadEnabled  out  1  to MEM/WB register
- writeBackEnabled  out  1  to MEM/WB register
- freeze  out  1  stalls PC, IF/ID, ID/EX and EX/MEM registers
- sramAddress  out  18  halfword address
- sramWriteData  out  16  halfword write data
- sramDriveEnable  out  1  drive write data onto the SRAM bus
- sramWriteEnable_n  out  1  active-low SRAM write strobe
- sramReadData  in  16  halfword read data

Function
REQ-004 SHALL compute the word address as (aluResult_in - 1024) >> 2, truncated to 17 bits (modulo wrap), and sramAddress = {wordAddress, half}, with half = 0 for the low half and 1 for the high half.
REQ-005 SHALL implement the FSM IDLE -> LOW -> HIGH -> DONE -> IDLE.
- IDLE leaves only when a read or write request is asserted.
- LOW and HIGH each last exactly WAIT_CYCLES cycles, counted by a 4-bit counter that clears on every state entry.
- DONE lasts one cycle and returns to IDLE unconditionally.
REQ-006 freeze SHALL be asserted combinationally in IDLE when a request is present, and in LOW and HIGH; it SHALL be 0 in DONE and in IDLE with no request.
REQ-007 For an access with WAIT_CYCLES = W, freeze SHALL be high for exactly 1 + 2W consecutive cycles; the instruction completes in the DONE cycle.
REQ-008 On a read, SHALL capture sramReadData into data[15:0] on the last LOW cycle and into data[31:16] on the last HIGH cycle.
REQ-009 data SHALL hold its last assembled value until the next read overwrites it.
REQ-010 On a write:
- sramDriveEnable = 1 and sramWriteEnable_n = 0 throughout LOW and HIGH.
- sramWriteData = storeValue_in[15:0] in LOW and storeValue_in[31:16] in HIGH.
- Otherwise sramDriveEnable = 0 and sramWriteEnable_n = 1.
REQ-011 If both read and write requests are asserted, SHALL perform the write; memoryReadEnabled still propagates.
REQ-012 destination and aluResult SHALL be combinational pass-throughs of their inputs.
REQ-013 memoryReadEnabled and writeBackEnabled SHALL equal their inputs ANDed with ~freeze, so MEM/WB never captures an incomplete access.
REQ-014 Inputs are held stable by upstream freeze during an access; the block SHALL NOT re-sample the request until it returns to IDLE.
REQ-015 Back-to-back memory instructions SHALL each incur the full 1 + 2W freeze with exactly one unfrozen DONE cycle between them.
REQ-016 Non-memory instructions SHALL pass with zero added latency and freeze = 0.

Reset
REQ-017 While rst = 1 at a clock edge, SHALL set state = IDLE, counter = 0 and data = 0.
REQ-018 While rst = 1, SHALL force freeze = 0, sramWriteEnable_n = 1 and sramDriveEnable = 0.
REQ-019 Reset asserted mid-access SHALL abort the access; a partial SRAM write is permitted and no write-back occurs.

Structure
REQ-020 A shared package SHALL hold:
- FSM state encoding (2 bits)
- DATA_MEMORY_BASE = 1024
- SRAM_ADDRESS_WIDTH = 18
- SRAM_DATA_WIDTH = 16
REQ-021 The FSM, counter, data assembly and SRAM drive logic SHALL live in one sub-module, SramController; MemoryStage holds the address computation, pass-throughs and gating.

Verification
REQ-022 The bench SHALL cover these directed scenarios (W = 2 unless stated):
- Load aluResult_in = 1032, sram model returns 0x5678 at halfword address 4 and 0x1234 at halfword address 5 -> freeze high 5 cycles; DONE cycle shows data = 0x12345678 and writeBackEnabled = 1.
- Store aluResult_in = 1024, storeValue_in = 0xDEADBEEF -> sramWriteEnable_n low 4 cycles; writes 0xBEEF at address 0, then 0xDEAD at address 1.
- ADD with no memory access -> freeze = 0 every cycle; outputs equal inputs the same cycle.
- Load, then load -> two 5-cycle freezes separated by exactly one freeze = 0 cycle.
- rst asserted on cycle 3 of a load -> next cycle state = IDLE, data = 0, writeBackEnabled = 0, sramWriteEnable_n = 1.
- WAIT_CYCLES = 1, load -> freeze high 3 cycles; data assembled correctly.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM encoding,
// data-memory base and SRAM geometry, plus the word-address helper.
package memory_stage_pkg;

  localparam int DATA_MEMORY_BASE = 1024;
  localparam int SRAM_ADDRESS_WIDTH = 18;
  localparam int SRAM_DATA_WIDTH = 16;
  localparam int WORD_ADDRESS_WIDTH = SRAM_ADDRESS_WIDTH - 1;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOW  = 2'b01;
  localparam logic [1:0] ST_HIGH = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  // Byte address -> 32-bit word index inside the SRAM.
  // The subtraction wraps, and the result is cut to the SRAM word range.
  function automatic logic [WORD_ADDRESS_WIDTH-1:0] word_address(
    input logic [31:0] addr
  );
    logic [31:0] off;
    off = addr - 32'(DATA_MEMORY_BASE);
    return off[WORD_ADDRESS_WIDTH+1:2];
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Halfword SRAM bus between the MEM stage (master) and the SRAM (slave).
// Ports: sramAddress, sramWriteData, sramDriveEnable, sramWriteEnable_n, sramReadData.
interface memory_stage_if;
  import memory_stage_pkg::*;

  logic [SRAM_ADDRESS_WIDTH-1:0] sramAddress;
  logic [SRAM_DATA_WIDTH-1:0]    sramWriteData;
  logic                          sramDriveEnable;
  logic                          sramWriteEnable_n;
  logic [SRAM_DATA_WIDTH-1:0]    sramReadData;

  modport master (
    output sramAddress,
    output sramWriteData,
    output sramDriveEnable,
    output sramWriteEnable_n,
    input  sramReadData
  );

  modport slave (
    input  sramAddress,
    input  sramWriteData,
    input  sramDriveEnable,
    input  sramWriteEnable_n,
    output sramReadData
  );

endinterface

// File: rtl/memory_stage_sram_controller.sv
// Two-halfword SRAM sequencer: IDLE -> LOW -> HIGH -> DONE with WAIT_CYCLES per half.
// Ports: clk, rst, read_i/write_i requests, store_value_i, read_data_i in;
//        freeze_o, high_o (address LSB), write_data_o, drive_o, write_n_o, data_o out.
module sram_controller
  import memory_stage_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       read_i,
  input  logic                       write_i,
  input  logic [31:0]                store_value_i,
  input  logic [SRAM_DATA_WIDTH-1:0] read_data_i,
  output logic                       freeze_o,
  output logic                       high_o,
  output logic [SRAM_DATA_WIDTH-1:0] write_data_o,
  output logic                       drive_o,
  output logic                       write_n_o,
  output logic [31:0]                data_o
);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] data_q, data_d;

  logic req;
  logic last;
  logic in_low;
  logic in_high;
  logic in_idle;

  assign req     = read_i | write_i;
  assign last    = (cnt_q == 4'(WAIT_CYCLES - 1));
  assign in_idle = (state_q == ST_IDLE);
  assign in_low  = (state_q == ST_LOW);
  assign in_high = (state_q == ST_HIGH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = 4'd0;
        if (req) begin
          state_d = ST_LOW;
          // A write wins when both requests are raised.
          wr_d    = write_i;
        end
      end
      ST_LOW: begin
        if (last) begin
          state_d = ST_HIGH;
          cnt_d   = 4'd0;
          if (!wr_q) data_d[15:0] = read_data_i;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_HIGH: begin
        if (last) begin
          state_d = ST_DONE;
          cnt_d   = 4'd0;
          if (!wr_q) data_d[31:16] = read_data_i;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
    end
  end

  // The IDLE term is combinational so the upstream stages hold
  // the instruction in the very cycle the request appears.
  assign freeze_o = ~rst & ((in_idle & req) | in_low | in_high);

  assign drive_o      = ~rst & wr_q & (in_low | in_high);
  assign write_n_o    = ~drive_o;
  assign high_o       = in_high;
  assign write_data_o = in_high ? store_value_i[31:16]
                                : store_value_i[15:0];
  assign data_o       = data_q;

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: SRAM address generation, EX/MEM -> MEM/WB pass-through,
// and write-back gating while an access is in flight.
// Ports: clk, rst; EX/MEM inputs *_in; MEM/WB outputs; freeze; sram bus (master).
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            destination_in,
  input  logic [31:0]           aluResult_in,
  input  logic [31:0]           storeValue_in,
  input  logic                  memoryReadEnabled_in,
  input  logic                  memoryWriteEnabled_in,
  input  logic                  writeBackEnabled_in,
  output logic [3:0]            destination,
  output logic [31:0]           data,
  output logic [31:0]           aluResult,
  output logic                  memoryReadEnabled,
  output logic                  writeBackEnabled,
  output logic                  freeze,
  memory_stage_if.master        sram
);

  logic [WORD_ADDRESS_WIDTH-1:0] word_addr;
  logic                          high;
  logic                          freeze_int;

  assign word_addr = word_address(aluResult_in);

  sram_controller #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .read_i        (memoryReadEnabled_in),
    .write_i       (memoryWriteEnabled_in),
    .store_value_i (storeValue_in),
    .read_data_i   (sram.sramReadData),
    .freeze_o      (freeze_int),
    .high_o        (high),
    .write_data_o  (sram.sramWriteData),
    .drive_o       (sram.sramDriveEnable),
    .write_n_o     (sram.sramWriteEnable_n),
    .data_o        (data)
  );

  assign sram.sramAddress = {word_addr, high};

  assign freeze      = freeze_int;
  assign destination = destination_in;
  assign aluResult   = aluResult_in;

  // MEM/WB must never latch a half-finished access.
  assign memoryReadEnabled = memoryReadEnabled_in & ~freeze_int;
  assign writeBackEnabled  = writeBackEnabled_in & ~freeze_int;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: W=2 and W=1 instances,
// each with its own halfword SRAM model and a word-level reference.
module tb_memory_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  dst[2];
  logic [31:0] alu[2];
  logic [31:0] sv[2];
  logic        rd[2];
  logic        wr[2];
  logic        wb[2];

  logic [3:0]  o_dst[2];
  logic [31:0] o_data[2];
  logic [31:0] o_alu[2];
  logic        o_rd[2];
  logic        o_wb[2];
  logic        frz[2];

  memory_stage_if s0 ();
  memory_stage_if s1 ();

  memory_stage #(.WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst),
    .destination_in(dst[0]), .aluResult_in(alu[0]),
    .storeValue_in(sv[0]), .memoryReadEnabled_in(rd[0]),
    .memoryWriteEnabled_in(wr[0]), .writeBackEnabled_in(wb[0]),
    .destination(o_dst[0]), .data(o_data[0]), .aluResult(o_alu[0]),
    .memoryReadEnabled(o_rd[0]), .writeBackEnabled(o_wb[0]),
    .freeze(frz[0]), .sram(s0)
  );

  memory_stage #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .destination_in(dst[1]), .aluResult_in(alu[1]),
    .storeValue_in(sv[1]), .memoryReadEnabled_in(rd[1]),
    .memoryWriteEnabled_in(wr[1]), .writeBackEnabled_in(wb[1]),
    .destination(o_dst[1]), .data(o_data[1]), .aluResult(o_alu[1]),
    .memoryReadEnabled(o_rd[1]), .writeBackEnabled(o_wb[1]),
    .freeze(frz[1]), .sram(s1)
  );

  logic [17:0] sa[2];
  logic [15:0] wdat[2];
  logic        drv[2];
  logic        wen[2];
  assign sa[0]   = s0.sramAddress;
  assign sa[1]   = s1.sramAddress;
  assign wdat[0] = s0.sramWriteData;
  assign wdat[1] = s1.sramWriteData;
  assign drv[0]  = s0.sramDriveEnable;
  assign drv[1]  = s1.sramDriveEnable;
  assign wen[0]  = s0.sramWriteEnable_n;
  assign wen[1]  = s1.sramWriteEnable_n;

  int unsigned seed;
  logic        init_go;
  logic [15:0] mem0[1024];
  logic [15:0] mem1[1024];
  int          wel0 = 0;
  int          wel1 = 0;

  function automatic logic [15:0] h(int s, int i);
    return 16'((i * 40503) ^ int'(seed) ^ (s * 7919));
  endfunction

  assign s0.sramReadData = mem0[s0.sramAddress[9:0]];
  assign s1.sramReadData = mem1[s1.sramAddress[9:0]];

  always @(posedge clk) begin
    if (init_go) begin
      for (int i = 0; i < 1024; i++) mem0[i] <= h(0, i);
      mem0[4] <= 16'h5678;
      mem0[5] <= 16'h1234;
    end else if (!s0.sramWriteEnable_n) begin
      mem0[s0.sramAddress[9:0]] <= s0.sramWriteData;
    end
    if (!s0.sramWriteEnable_n) wel0 <= wel0 + 1;
  end

  always @(posedge clk) begin
    if (init_go) begin
      for (int i = 0; i < 1024; i++) mem1[i] <= h(1, i);
      mem1[4] <= 16'h5678;
      mem1[5] <= 16'h1234;
    end else if (!s1.sramWriteEnable_n) begin
      mem1[s1.sramAddress[9:0]] <= s1.sramWriteData;
    end
    if (!s1.sramWriteEnable_n) wel1 <= wel1 + 1;
  end

  // Reference: halfword memory image and last loaded word per instance.
  logic [15:0] refm[2][1024];
  logic [31:0] lastd[2];
  int errors = 0;
  int checks = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int wc(int s);
    return (s == 0) ? 2 : 1;
  endfunction

  function automatic logic [15:0] memrd(int s, int i);
    return (s == 0) ? mem0[i] : mem1[i];
  endfunction

  task automatic clear_all();
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; wb[i] = 1'b0;
      dst[i] = 4'd0; alu[i] = 32'd0; sv[i] = 32'd0;
    end
  endtask

  task automatic drive(int s, bit r, bit w, bit b,
                       logic [3:0] d, logic [31:0] a, logic [31:0] v);
    clear_all();
    rd[s] = r; wr[s] = w; wb[s] = b;
    dst[s] = d; alu[s] = a; sv[s] = v;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    clear_all();
    @(negedge clk);
    chk("idle_freeze", {31'd0, frz[0] | frz[1]}, 32'd0);
  endtask

  task automatic access(int s, bit r, bit w, bit b,
                        logic [3:0] d, logic [31:0] a, logic [31:0] v);
    int W;
    int n;
    int bad;
    int we_before;
    bit mem_op;
    bit hh;
    logic [31:0] off;
    logic [16:0] wa;
    int lo;
    int hi;
    W = wc(s);
    n = 0;
    bad = 0;
    mem_op = r | w;
    off = (a - 32'd1024) >> 2;
    wa = off[16:0];
    lo = (2 * int'(wa)) & 1023;
    hi = (2 * int'(wa) + 1) & 1023;
    @(posedge clk); #1;
    drive(s, r, w, b, d, a, v);
    we_before = (s == 0) ? wel0 : wel1;
    @(negedge clk);
    if (mem_op) chk("addr_first", {14'd0, sa[s]}, {14'd0, wa, 1'b0});
    while (frz[s] === 1'b1 && n < 40) begin
      n++;
      if (o_wb[s] !== 1'b0 || o_rd[s] !== 1'b0) bad++;
      if (n > 1) begin
        hh = (n > W + 1);
        if (sa[s] !== {wa, hh}) bad++;
        if (w) begin
          if (wen[s] !== 1'b0 || drv[s] !== 1'b1) bad++;
          if (wdat[s] !== (hh ? v[31:16] : v[15:0])) bad++;
        end else if (wen[s] !== 1'b1 || drv[s] !== 1'b0) begin
          bad++;
        end
      end
      @(negedge clk);
    end
    chk("freeze_len", n, mem_op ? 1 + 2 * W : 0);
    chk("frozen_cycles", bad, 0);
    chk("wb_out", {31'd0, o_wb[s]}, {31'd0, b});
    chk("rd_out", {31'd0, o_rd[s]}, {31'd0, r});
    chk("dst_out", {28'd0, o_dst[s]}, {28'd0, d});
    chk("alu_out", o_alu[s], a);
    if (r && !w) lastd[s] = {refm[s][hi], refm[s][lo]};
    if (w) begin
      refm[s][lo] = v[15:0];
      refm[s][hi] = v[31:16];
    end
    chk("data", o_data[s], lastd[s]);
    chk("strobe_cycles", ((s == 0) ? wel0 : wel1) - we_before,
        w ? 2 * W : 0);
    if (w) begin
      chk("mem_lo", {16'd0, memrd(s, lo)}, {16'd0, v[15:0]});
      chk("mem_hi", {16'd0, memrd(s, hi)}, {16'd0, v[31:16]});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    seed = $urandom;
    rst = 1'b1;
    init_go = 1'b1;
    clear_all();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 1024; i++) refm[s][i] = h(s, i);
      refm[s][4] = 16'h5678;
      refm[s][5] = 16'h1234;
      lastd[s] = 32'd0;
    end
    @(posedge clk); #1;
    init_go = 1'b0;
    rd[0] = 1'b1; wr[1] = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_freeze", {31'd0, frz[s]}, 32'd0);
      chk("rst_we_n", {31'd0, wen[s]}, 32'd1);
      chk("rst_drive", {31'd0, drv[s]}, 32'd0);
      chk("rst_data", o_data[s], 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_all();
    @(negedge clk);
    chk("post_rst_freeze", {31'd0, frz[0] | frz[1]}, 32'd0);

    access(0, 1, 0, 1, 4'd3, 32'd1032, 32'd0);
    chk("load_1032", o_data[0], 32'h12345678);
    idle();

    access(0, 0, 1, 0, 4'd0, 32'd1024, 32'hDEADBEEF);
    chk("store_beef", {16'd0, mem0[0]}, 32'h0000BEEF);
    chk("store_dead", {16'd0, mem0[1]}, 32'h0000DEAD);
    idle();

    for (int k = 0; k < 4; k++) begin
      access(k % 2, 0, 0, 1, 4'($urandom), $urandom, $urandom);
    end

    access(0, 1, 0, 1, 4'd5, 32'd1032, 32'd0);
    access(0, 1, 0, 1, 4'd6, 32'd1024, 32'd0);
    chk("b2b_data", o_data[0], 32'hDEADBEEF);
    idle();

    access(1, 1, 0, 1, 4'd7, 32'd1032, 32'd0);
    chk("w1_load", o_data[1], 32'h12345678);
    idle();

    access(0, 1, 1, 1, 4'd8, 32'd1060, 32'hCAFEF00D);
    access(0, 1, 0, 1, 4'd9, 32'd1060, 32'd0);
    chk("both_then_load", o_data[0], 32'hCAFEF00D);

    access(0, 1, 0, 1, 4'd10, 32'd16, 32'd0);
    idle();

    for (int k = 0; k < 24; k++) begin
      int s;
      int kind;
      logic [31:0] a;
      s = int'($urandom % 2);
      kind = int'($urandom % 3);
      a = 32'd1024 + 32'(4 * ($urandom % 480)) + 32'($urandom % 4);
      if (kind == 2) a = $urandom;
      access(s, kind == 0, kind == 1, kind != 1,
             4'($urandom), a, $urandom);
      if ($urandom % 2 == 0) idle();
    end
    idle();

    // Abort a load on its third frozen cycle.
    @(posedge clk); #1;
    drive(0, 1, 0, 1, 4'd2, 32'd1040, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_freeze", {31'd0, frz[0]}, 32'd0);
    chk("abort_rst_we_n", {31'd0, wen[0]}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_all();
    lastd[0] = 32'd0;
    lastd[1] = 32'd0;
    @(negedge clk);
    chk("abort_data", o_data[0], 32'd0);
    chk("abort_wb", {31'd0, o_wb[0]}, 32'd0);
    chk("abort_we_n", {31'd0, wen[0]}, 32'd1);
    chk("abort_freeze", {31'd0, frz[0]}, 32'd0);

    // Abort a store during its high half.
    @(posedge clk); #1;
    drive(1, 0, 1, 1, 4'd1, 32'd3024, 32'h01234567);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_st_drive", {31'd0, drv[1]}, 32'd0);
    chk("abort_st_we_n", {31'd0, wen[1]}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_all();
    @(negedge clk);
    chk("abort_st_freeze", {31'd0, frz[1]}, 32'd0);
    chk("abort_st_data", o_data[1], 32'd0);

    access(0, 1, 0, 1, 4'd4, 32'd1024, 32'd0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
